// File: rtl/dec_hold_2to4_if.sv
// Handshake bundle between the priority-encoder stage, the hold decoder and
// the per-line consumers. The decoder side uses the slave modport.
interface dec_hold_2to4_if #(
  parameter int IDX_W = 2
);
  logic [IDX_W-1:0]        in_idx;
  logic                    in_valid;
  logic                    in_ready;
  logic [(1<<IDX_W)-1:0]   out_onehot;
  logic                    out_valid;
  logic                    out_ack;

  modport master (
    output in_idx,
    output in_valid,
    output out_ack,
    input  in_ready,
    input  out_onehot,
    input  out_valid
  );

  modport slave (
    input  in_idx,
    input  in_valid,
    input  out_ack,
    output in_ready,
    output out_onehot,
    output out_valid
  );
endinterface

// File: rtl/dec_hold_2to4.sv
// Sequential index-to-one-hot decoder. An accepted index is expanded to a
// registered one-hot line that stays up for at least HOLD_CYC cycles and then
// until the consumer acknowledges it, or until the timeout aborts it.
module dec_hold_2to4 #(
  parameter int IDX_W    = 2,
  parameter int HOLD_CYC = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_hold_2to4_if.slave       bus,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     txn_cnt,
  output logic                 busy
);

  localparam int OH_W = 1 << IDX_W;
  // Counters only need to hold the reload value (parameter - 1).
  localparam int HCW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int TOW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = (HOLD_CYC > 0) ? HCW'(HOLD_CYC - 1) : '0;
  localparam logic [TOW-1:0] TO_LOAD   = (TIMEOUT > 0) ? TOW'(TIMEOUT - 1) : '0;
  localparam bit HOLD_EN = (HOLD_CYC > 0);
  localparam bit TO_EN   = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t             state_r,    state_s;
  logic [HCW-1:0]     hold_cnt_r, hold_cnt_s;
  logic [TOW-1:0]     to_cnt_r,   to_cnt_s;
  logic               ack_seen_r, ack_seen_s;
  logic [OH_W-1:0]    onehot_r,   onehot_s;
  logic               valid_r,    valid_s;
  logic               err_r,      err_s;
  logic [CNT_W-1:0]   cnt_r,      cnt_s;
  logic               to_fire_s;

  // Expand an index into its one-hot line.
  function automatic logic [OH_W-1:0] decode_idx(input logic [IDX_W-1:0] idx);
    logic [OH_W-1:0] oh;
    oh = '0;
    for (int i = 0; i < OH_W; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  // Next-state, counter and output-register computation.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    to_cnt_s   = to_cnt_r;
    ack_seen_s = ack_seen_r;
    onehot_s   = onehot_r;
    valid_s    = valid_r;
    cnt_s      = cnt_r;
    to_fire_s  = 1'b0;

    case (state_r)
      IDLE: begin
        // out_ack is deliberately ignored here.
        if (bus.in_valid) begin
          onehot_s   = decode_idx(bus.in_idx);
          valid_s    = 1'b1;
          cnt_s      = cnt_r + CNT_W'(1);
          ack_seen_s = 1'b0;
          if (HOLD_EN) begin
            state_s    = HOLD;
            hold_cnt_s = HOLD_LOAD;
          end else begin
            state_s  = WAIT_ACK;
            to_cnt_s = TO_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end

      HOLD: begin
        if (hold_cnt_r == '0) begin
          if (ack_seen_r || bus.out_ack) begin
            state_s  = IDLE;
            onehot_s = '0;
            valid_s  = 1'b0;
          end else begin
            state_s  = WAIT_ACK;
            to_cnt_s = TO_LOAD;
          end
        end else begin
          hold_cnt_s = hold_cnt_r - HCW'(1);
          if (bus.out_ack) begin
            ack_seen_s = 1'b1;
          end else begin
            ack_seen_s = ack_seen_r;
          end
        end
      end

      WAIT_ACK: begin
        // Ack is checked first so it wins over a simultaneous expiry.
        if (bus.out_ack) begin
          state_s  = IDLE;
          onehot_s = '0;
          valid_s  = 1'b0;
        end else if (TO_EN && (to_cnt_r == '0)) begin
          state_s   = IDLE;
          onehot_s  = '0;
          valid_s   = 1'b0;
          to_fire_s = 1'b1;
        end else begin
          to_cnt_s = to_cnt_r - TOW'(1);
        end
      end

      default: begin
        state_s  = IDLE;
        onehot_s = '0;
        valid_s  = 1'b0;
      end
    endcase

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (to_fire_s) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      to_cnt_r   <= '0;
      ack_seen_r <= 1'b0;
      onehot_r   <= '0;
      valid_r    <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= '0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      to_cnt_r   <= to_cnt_s;
      ack_seen_r <= ack_seen_s;
      onehot_r   <= onehot_s;
      valid_r    <= valid_s;
      err_r      <= err_s;
      cnt_r      <= cnt_s;
    end
  end

  assign bus.in_ready   = (state_r == IDLE);
  assign bus.out_onehot = onehot_r;
  assign bus.out_valid  = valid_r;
  assign busy           = (state_r != IDLE);
  assign timeout_err    = err_r;
  assign txn_cnt        = cnt_r;

endmodule

// File: tb/tb_dec_hold_2to4.sv
// Directed bench for dec_hold_2to4 with a transaction scoreboard.
module tb_dec_hold_2to4;

  localparam int HOLD = 4;
  localparam int TO   = 16;
  localparam int M_HELD  = 0;
  localparam int M_PULSE = 1;
  localparam int M_NONE  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       timeout_err;
  logic       err_clr;
  logic [7:0] txn_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] onehot;
    int         len;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic       err_model;
  logic [7:0] cnt_model;

  dec_hold_2to4_if #(.IDX_W(2)) bus ();

  dec_hold_2to4 #(
    .IDX_W(2), .HOLD_CYC(HOLD), .TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .timeout_err(timeout_err),
    .err_clr(err_clr),
    .txn_cnt(txn_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected number of cycles out_valid stays high.
  function automatic int exp_len(input int mode, input int ack_k);
    if (mode == M_HELD) return HOLD;
    if (mode == M_PULSE) begin
      if (ack_k <= HOLD) return HOLD;
      if (ack_k <= HOLD + TO) return ack_k;
    end
    return HOLD + TO;
  endfunction

  function automatic bit exp_timeout(input int mode, input int ack_k);
    return (mode == M_NONE) || (mode == M_PULSE && ack_k > HOLD + TO);
  endfunction

  // Runs one transaction; must be called at a falling edge with the DUT idle.
  // ack_k is the rising edge (1 = first edge after acceptance) where a pulse is sampled.
  task automatic run_txn(input logic [1:0] idx, input int mode, input int ack_k,
                         input bit clr_at_expiry);
    exp_t e;
    int   len;
    int   k;
    bit   to;
    logic [3:0] oh_one;
    oh_one   = 4'b0001;
    to       = exp_timeout(mode, ack_k);
    e.onehot = oh_one << idx;
    e.len    = exp_len(mode, ack_k);
    err_model = to ? 1'b1 : (clr_at_expiry ? 1'b0 : err_model);
    e.err    = err_model;
    cnt_model = cnt_model + 8'd1;
    e.cnt    = cnt_model;
    sb_q.push_back(e);

    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_idx   = idx;
    bus.in_valid = 1'b1;
    bus.out_ack  = (mode == M_HELD);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_idx   = ~idx;
    len = 0;
    k   = 1;
    while (bus.out_valid === 1'b1 && len < 100) begin
      len++;
      chk("onehot_active", {28'd0, bus.out_onehot}, {28'd0, e.onehot});
      chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
      bus.out_ack = (mode == M_HELD) || (mode == M_PULSE && k == ack_k);
      err_clr     = clr_at_expiry && (k == HOLD + TO);
      @(negedge clk);
      k++;
    end
    bus.out_ack = 1'b0;
    err_clr     = 1'b0;

    e = sb_q.pop_front();
    chk("valid_len", 32'(len), 32'(e.len));
    chk("onehot_idle", {28'd0, bus.out_onehot}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.err});
    chk("txn_cnt", {24'd0, txn_cnt}, {24'd0, e.cnt});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    err_model = 1'b0;
    cnt_model = 8'd0;
  endtask

  initial begin
    bus.in_idx   = 2'd0;
    bus.in_valid = 1'b0;
    bus.out_ack  = 1'b0;
    err_clr      = 1'b0;
    err_model    = 1'b0;
    cnt_model    = 8'd0;
    do_reset();

    // Reset values
    chk("rst_onehot", {28'd0, bus.out_onehot}, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_cnt", {24'd0, txn_cnt}, 32'd0);

    // Reset in the middle of HOLD acts without a clock edge
    @(negedge clk);
    bus.in_idx   = 2'd2;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midhold_onehot", {28'd0, bus.out_onehot}, 32'h4);
    chk("midhold_cnt", {24'd0, txn_cnt}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_onehot", {28'd0, bus.out_onehot}, 32'd0);
    chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_cnt", {24'd0, txn_cnt}, 32'd0);
    do_reset();
    #1;
    chk("post_rst_cnt", {24'd0, txn_cnt}, 32'd0);
    @(negedge clk);

    // Basic decode with ack held high
    run_txn(2'd3, M_HELD, 0, 1'b0);
    // Early single-cycle ack in the second HOLD cycle
    run_txn(2'd1, M_PULSE, 2, 1'b0);
    // Late ack in WAIT_ACK
    run_txn(2'd0, M_PULSE, HOLD + 6, 1'b0);
    // Timeout, then clear the sticky flag
    run_txn(2'd2, M_NONE, 0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_model = 1'b0;
    chk("err_cleared", {31'd0, timeout_err}, 32'd0);
    // Ack arriving on the expiry edge wins
    run_txn(2'd3, M_PULSE, HOLD + TO, 1'b0);
    // err_clr on the expiry edge loses to the set
    run_txn(2'd1, M_NONE, 0, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_model = 1'b0;
    chk("err_cleared2", {31'd0, timeout_err}, 32'd0);

    // 256 back-to-back transactions, counter wraps
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_txn(2'(i % 4), M_HELD, 0, 1'b0);
    end
    chk("wrap_cnt_zero", {24'd0, txn_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_hold_2to4.md
Name: dec_hold_2to4

Overview:
- Sequential decoder that consumes the {index, valid} pair produced by a priority encoder.
- Expands the index into a one-hot line and drives it for a guaranteed minimum time.
- Holds the line until a downstream acknowledge arrives, or until a timeout expires.
- Sits between the priority-encoder stage and the per-line consumers (grant / service lines), with a valid/ready handshake on the input side.

Parameters:
- IDX_W, 2: index width; one-hot output width is 2**IDX_W (default 4).
- HOLD_CYC, 4: minimum number of cycles out_valid/out_onehot stay asserted per transaction; 0 means no minimum.
- TIMEOUT, 16: maximum cycles spent in WAIT_ACK before an abort; 0 disables the timeout.
- CNT_W, 8: width of the accepted-transaction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_idx  in  IDX_W  encoded index from the priority encoder.
- in_valid  in  1  in_idx is valid (encoder v output).
- in_ready  out  1  block can accept a new index.
- out_onehot  out  2**IDX_W  decoded one-hot line, registered.
- out_valid  out  1  out_onehot is active.
- out_ack  in  1  downstream has serviced the active line.
- timeout_err  out  1  sticky flag: a transaction was aborted by the timeout.
- err_clr  in  1  synchronous clear of timeout_err.
- txn_cnt  out  CNT_W  count of accepted transactions, wraps.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - out_onehot=0, out_valid=0, timeout_err=0, txn_cnt=0.
  - Hold and timeout counters=0, ack_seen=0.
  - in_ready=1 and busy=0 are decoded from state.
  - Reset asserted mid-transaction aborts it immediately; outputs go to reset values without waiting for a clock edge.
- States: IDLE, HOLD, WAIT_ACK.
- in_ready = (state==IDLE), combinational from the state register.
- IDLE:
  - Acceptance is in_valid && in_ready at a rising edge.
  - On that edge: out_onehot <= 1<<in_idx, out_valid <= 1, txn_cnt <= txn_cnt+1 (wraps at 2**CNT_W), ack_seen <= 0.
  - Next state is HOLD with hold counter = HOLD_CYC-1 if HOLD_CYC>0, else WAIT_ACK.
  - Latency: accept at edge N; out_valid is visible from edge N to edge N+HOLD_CYC at minimum.
  - out_ack in IDLE is ignored.
- HOLD:
  - Hold counter decrements each cycle.
  - out_ack seen in any HOLD cycle sets ack_seen.
  - When the counter is 0:
    - If ack_seen or out_ack, go to IDLE and clear out_onehot/out_valid on that edge.
    - Otherwise go to WAIT_ACK and load the timeout counter with TIMEOUT-1.
- WAIT_ACK:
  - out_ack=1: go to IDLE and clear outputs on that edge.
  - Otherwise, if TIMEOUT>0 and the timeout counter is 0: go to IDLE, clear outputs, set timeout_err.
  - Otherwise the timeout counter decrements.
- out_onehot is stable and exactly one-hot for the whole time out_valid=1. It is all-zero whenever out_valid=0.
- in_idx is sampled only at acceptance; changes on in_idx after that are ignored.
- Back-to-back transactions: one IDLE cycle minimum between transactions, so out_valid drops for at least one cycle.
- Same-cycle events:
  - out_ack coinciding with the timeout expiry: the ack wins and timeout_err is not set.
  - err_clr coinciding with a timeout: the set wins and timeout_err stays 1.
- timeout_err holds until err_clr=1 or reset.
- in_valid with in_idx out of range cannot occur, because the one-hot width is 2**IDX_W.

Test Plan:
- Reset mid-HOLD: accept idx=2, assert rst_n=0 two cycles later -> out_onehot=0000, out_valid=0, busy=0 immediately; txn_cnt=0 after reset.
- Basic decode, defaults: in_idx=3, in_valid=1, out_ack held 1 -> out_onehot=1000 for exactly 4 cycles, then 0000, in_ready=1, txn_cnt=1.
- Early ack: idx=1, single-cycle out_ack during the 2nd HOLD cycle -> out_onehot=0010 held the full 4 cycles, returns to IDLE with no WAIT_ACK cycle.
- Late ack: idx=0, out_ack pulsed 5 cycles after HOLD ends -> out_onehot=0001 high 4+6 cycles, timeout_err=0.
- Timeout: idx=2, out_ack never asserted -> out_valid high 4+16 cycles, then 0, timeout_err=1; err_clr pulse -> timeout_err=0.
- Throughput and wrap: 256 back-to-back accepts with idx cycling 0..3 and ack held 1 -> each output one-hot matches its idx, in_ready low during every transaction, txn_cnt wraps to 0.
